// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide; stalls EX until done.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [XLEN-1:0]     dvs_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    logic                is_div;
    logic                sgn_a;
    logic                sgn_b;
    logic                neg_a;
    logic                neg_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                neg_d;
    logic                div0;
    logic                ovf;
    logic [XLEN-1:0]     special_d;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rsh;
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   acc_d;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     result_d;

    always_comb begin
        is_div = op_q[2];
        sgn_a  = is_div ? ~op_q[0]
                        : (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
        sgn_b  = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
        neg_a  = sgn_a & a_q[XLEN-1];
        neg_b  = sgn_b & b_q[XLEN-1];
        mag_a  = neg_a ? -a_q : a_q;
        mag_b  = neg_b ? -b_q : b_q;
        // Remainder follows the dividend; everything else uses the xor.
        neg_d  = (is_div & op_q[1]) ? neg_a : (neg_a ^ neg_b);
        div0   = is_div && (b_q == '0);
        ovf    = is_div && !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
        if (div0) begin
            special_d = op_q[1] ? a_q : '1;
        end else begin
            special_d = op_q[1] ? '0 : a_q;
        end
    end

    // One iteration: hi half is the partial sum / partial remainder.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
        rsh     = acc_q[2*XLEN-1:XLEN-1];
        trial   = rsh - {1'b0, dvs_q};
        if (is_div) begin
            if (!trial[XLEN]) begin
                acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (is_div) begin
            result_d = op_q[1] ? rem : quot;
        end else if (op_q[1:0] == 2'b00) begin
            result_d = prod[XLEN-1:0];
        end else begin
            result_d = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvs_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= funct3;
                        a_q     <= rs1;
                        b_q     <= rs2;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    cnt_q <= '0;
                    if (div0 || ovf) begin
                        result_q <= special_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q   <= {{XLEN{1'b0}}, mag_a};
                        dvs_q   <= mag_b;
                        neg_q   <= neg_d;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = busy_q | ((state_q == S_IDLE) & start & ~flush);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed checks of muldiv_sequencer against
// a plain-arithmetic RV32M reference.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail = 0;

    muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .flush(flush),
        .funct3(funct3),
        .rs1(rs1),
        .rs2(rs2),
        .busy(busy),
        .stall(stall),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        p = '0;
        case (f)
            3'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            3'd1: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                return p[63:32];
            end
            3'd2: begin
                p = {{32{a[31]}}, a} * {32'b0, b};
                return p[63:32];
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Called just after a falling edge; returns in the done cycle.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        logic [31:0] expv;
        int          lat;
        int          exp_lat;
        int          busy_cnt;
        bit          special;
        expv = ref_model(f, a, b);
        special = f[2] && (b == 0 ||
                  (!f[0] && a == MINV && b == 32'hFFFF_FFFF));
        exp_lat = special ? 2 : XLEN + 3;
        funct3 = f;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        #1;
        check({tag, " stall@T"}, 32'(stall), 32'd1);
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) check({tag, " stall@T+1"}, 32'(stall), 32'd1);
            if (busy) busy_cnt++;
            if (done) lat = k;
        end
        if (lat == 0) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " latency"}, 32'(lat), 32'(exp_lat));
            check({tag, " result"}, result, expv);
            check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
            check({tag, " busy@done"}, 32'(busy), 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dn;
        int first;
        int second;

        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "MUL");
        @(negedge clk);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
        @(negedge clk);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH");
        @(negedge clk);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV");
        @(negedge clk);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM");
        @(negedge clk);
        do_op(3'd5, 32'd100, 32'd7, "DIVU");
        @(negedge clk);
        do_op(3'd7, 32'd100, 32'd7, "REMU");
        @(negedge clk);
        do_op(3'd4, 32'd5, 32'd0, "DIV0");
        @(negedge clk);
        do_op(3'd6, 32'd5, 32'd0, "REM0");
        @(negedge clk);
        do_op(3'd4, MINV, 32'hFFFF_FFFF, "DIVOVF");
        @(negedge clk);
        do_op(3'd6, MINV, 32'hFFFF_FFFF, "REMOVF");
        @(negedge clk);
        do_op(3'd2, MINV, 32'hFFFF_FFFF, "MULHSU");

        // Flush in the middle of a divide.
        @(negedge clk);
        do_op(3'd5, 32'd100, 32'd7, "pre-flush");
        @(negedge clk);
        funct3 = 3'd4;
        rs1 = 32'hFFFF_FFF9;
        rs2 = 32'd2;
        start = 1'b1;
        dn = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) dn++;
        check("flush no done", 32'(dn), 32'd0);
        check("flush busy", 32'(busy), 32'd0);
        check("flush result kept", result, 32'd14);
        do_op(3'd0, 32'd6, 32'd9, "after flush");

        // Flush together with start in IDLE.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("flush+start stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("flush+start busy2", 32'(busy), 32'd0);
        check("flush+start done", 32'(done), 32'd0);

        // Start held high across completion.
        funct3 = 3'd0;
        rs1 = 32'd3;
        rs2 = 32'd5;
        start = 1'b1;
        dn = 0;
        first = 0;
        second = 0;
        for (int k = 1; k <= 100 && dn < 2; k++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (dn == 1) first = k;
                else begin
                    second = k;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held first done", 32'(first), 32'd35);
        check("held gap", 32'(second - first), 32'd36);
        check("held result", result, 32'd15);

        // Reset in the middle of an operation.
        @(negedge clk);
        funct3 = 3'd0;
        rs1 = 32'd11;
        rs2 = 32'd13;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid result", result, 32'd0);
        check("rst mid done", 32'(done), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), "rand");
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
